// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths,
// the reset fetch address, the fetch FSM state type and the queue entry.
package ysyx_22050039_ifu_pkg;

  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } IfuState;

  // One buffered fetch: the address it came from, the word and its fault flag.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] inst;
    logic                err;
  } ifu_entry_t;

  // Instruction fetches are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] ifu_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22050039_ifu_if.sv
// Bundle of the fetch unit's memory, redirect, decode and performance
// signals. The master modport is the fetch unit's view; slave is the
// surrounding pipeline/memory view.
interface ysyx_22050039_ifu_if;
  import ysyx_22050039_ifu_pkg::*;

  // instruction memory request / response
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_addr;
  logic                imem_resp_valid;
  logic [INST_LEN-1:0] imem_resp_data;
  logic                imem_resp_err;

  // PC redirect from execute
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;

  // decode-side queue head
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     inst_pc;
  logic                inst_err;

  // performance counters
  logic [XLEN-1:0]     perf_fetch_cnt;
  logic [XLEN-1:0]     perf_stall_cnt;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_err,
    input  inst_ready,
    output perf_fetch_cnt, perf_stall_cnt
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_err,
    output inst_ready,
    input  perf_fetch_cnt, perf_stall_cnt
  );

endinterface

// File: rtl/ysyx_22050039_ifu_queue.sv
// Small FIFO of fetched instructions {pc, inst, err}. QDEPTH must be a
// power of two so the read/write pointers wrap naturally. A flush empties
// the queue in one cycle and overrides any push/pop of that cycle.
module ysyx_22050039_ifu_queue
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  ifu_entry_t       i_entry,
  output ifu_entry_t       o_head,
  output logic [CNT_W-1:0] o_count
);

  ifu_entry_t       r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(QDEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

  // Storage: write the incoming entry at the tail slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers and occupancy; flush returns everything to empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit. Owns the fetch PC, keeps at most one read in
// flight to instruction memory, and buffers returned words in a small
// queue for decode. Execute-stage redirects flush the queue and mark any
// in-flight read as wrong-path so its response is discarded.
// Optional feature macro: YSYX_22050039_IFU_PERF_EN enables the fetch and
// stall performance counters; without it both counter outputs read 0.
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int CNT_W  = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22050039_ifu_if.master   io
);

  IfuState          r_state;
  IfuState          w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  w_fetch_pc_nxt;
  logic [XLEN-1:0]  r_req_pc;
  logic [XLEN-1:0]  w_req_pc_nxt;
  logic             r_drop;
  logic             w_drop_nxt;

  logic [CNT_W-1:0] w_count;
  ifu_entry_t       w_head;
  ifu_entry_t       w_push_entry;

  logic             w_redirect;
  logic             w_req_valid;
  logic             w_hs;
  logic             w_resp;
  logic             w_push;
  logic             w_pop;
  logic             w_inst_valid;

  assign w_redirect   = io.redirect_valid;
  // Only ask for a new word when the queue is guaranteed room for it.
  assign w_req_valid  = (r_state == IFU_REQ) && (w_count < CNT_W'(QDEPTH));
  assign w_hs         = w_req_valid && io.imem_req_ready;
  assign w_resp       = (r_state == IFU_WAIT) && io.imem_resp_valid;
  assign w_inst_valid = (w_count != '0);
  // A redirect in the same cycle wins over both queue operations.
  assign w_push       = w_resp && !r_drop && !w_redirect;
  assign w_pop        = w_inst_valid && io.inst_ready && !w_redirect;

  assign w_push_entry = '{pc: r_req_pc, inst: io.imem_resp_data, err: io.imem_resp_err};

  // Next-state logic for the fetch FSM, fetch PC, request PC and drop flag.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;

    unique case (r_state)
      IFU_IDLE: begin
        w_state_nxt = IFU_REQ;
      end
      IFU_REQ: begin
        if (w_hs) begin
          w_state_nxt    = IFU_WAIT;
          w_req_pc_nxt   = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end
      end
      IFU_WAIT: begin
        if (io.imem_resp_valid) begin
          w_state_nxt = IFU_REQ;
          w_drop_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IFU_IDLE;
      end
    endcase

    // A redirect always retargets the fetch PC. Any read that is, or is
    // about to be, in flight belongs to the wrong path and must be dropped
    // when its response arrives; a response arriving now is simply ignored.
    if (w_redirect) begin
      w_fetch_pc_nxt = ifu_align(io.redirect_pc);
      if ((r_state == IFU_WAIT) && !io.imem_resp_valid) begin
        w_drop_nxt = 1'b1;
      end
      if ((r_state == IFU_REQ) && w_hs) begin
        w_drop_nxt = 1'b1;
      end
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IFU_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  ysyx_22050039_ifu_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign io.imem_req_valid = w_req_valid;
  assign io.imem_addr      = r_fetch_pc;
  assign io.inst_valid     = w_inst_valid;
  assign io.inst           = w_head.inst;
  assign io.inst_pc        = w_head.pc;
  assign io.inst_err       = w_head.err;

`ifdef YSYX_22050039_IFU_PERF_EN
  logic [XLEN-1:0] r_perf_fetch;
  logic [XLEN-1:0] r_perf_stall;

  // Count accepted (non-dropped) fetches and cycles decode sees nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetch <= r_perf_fetch + XLEN'(1);
      end
      if ((r_state != IFU_IDLE) && !w_inst_valid) begin
        r_perf_stall <= r_perf_stall + XLEN'(1);
      end
    end
  end

  assign io.perf_fetch_cnt = r_perf_fetch;
  assign io.perf_stall_cnt = r_perf_stall;
`else
  assign io.perf_fetch_cnt = '0;
  assign io.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Testbench for ysyx_22050039_ifu: a memory model with variable latency
// answers fetches with address-derived words, a stimulus process drives
// decode backpressure, redirects and resets, and a monitor checks every
// delivered instruction against the expected sequential-PC stream.
module tb_ysyx_22050039_ifu;
  import ysyx_22050039_ifu_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050039_ifu_if ifc();

  ysyx_22050039_ifu #(.QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  exp_t        exp_q[$];
  logic [63:0] mdl_pc;
  int n_cmp   = 0;
  int n_bad   = 0;
  int n_deliv = 0;
  int n_errs  = 0;
  int lat_lo  = 0;
  int lat_hi  = 0;
  int rdy_pct = 100;

  // Memory contents and fault map, both functions of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] ^ 32'h5A5A_0000;
    return (x * 32'h0001_0003) + 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return (a[5:2] == 4'h2) || ((a[11:2] % 10'd11) == 10'd3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Keep the expected stream topped up with sequential fetches.
  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = mdl_pc;
      e.inst = mem_word(mdl_pc);
      e.err  = mem_err(mdl_pc);
      exp_q.push_back(e);
      mdl_pc = mdl_pc + 64'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    refill();
  endtask

  task automatic do_redirect(input logic [63:0] target);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = target;
    exp_q.delete();
    mdl_pc = {target[63:2], 2'b00};
    refill();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ifc.redirect_valid = 1'b0;
    exp_q.delete();
    mdl_pc = RESET_PC;
    refill();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_hs(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (ifc.imem_req_valid && ifc.imem_req_ready) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: got no fetch handshake required one within 50 cycles", name);
    end
  endtask

  // Memory model: one outstanding read, response after lat_lo..lat_hi idle cycles.
  initial begin
    logic        m_busy;
    logic [63:0] m_addr;
    logic [63:0] a_now;
    logic        hs_now;
    int          m_wait;
    m_busy = 1'b0;
    m_addr = '0;
    m_wait = 0;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = '0;
    ifc.imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      hs_now = rst && ifc.imem_req_valid && ifc.imem_req_ready;
      a_now  = ifc.imem_addr;
      @(posedge clk);
      #1;
      ifc.imem_resp_valid = 1'b0;
      if (hs_now) begin
        m_busy = 1'b1;
        m_addr = a_now;
        m_wait = int'($urandom_range(lat_hi, lat_lo));
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end
      if (m_busy && m_wait == 0) begin
        ifc.imem_resp_valid = 1'b1;
        ifc.imem_resp_data  = mem_word(m_addr);
        ifc.imem_resp_err   = mem_err(m_addr);
        m_busy = 1'b0;
      end
      ifc.imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    end
  end

  // Monitor: every instruction decode accepts must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ifc.inst_valid && ifc.inst_ready && !ifc.redirect_valid) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deliver_extra: got pc %h required no delivery", ifc.inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", ifc.inst_pc, e.pc);
          chk("inst", 64'(ifc.inst), 64'(e.inst));
          chk("inst_err", 64'(ifc.inst_err), 64'(e.err));
          if (e.err) n_errs++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    int          e0;
    logic [63:0] t;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.inst_ready     = 1'b1;
    mdl_pc = RESET_PC;
    refill();

    // Reset values and first fetch from RESET_PC with a one-cycle memory.
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("rst_addr", ifc.imem_addr, RESET_PC);
    chk("rst_inst_valid", 64'(ifc.inst_valid), 64'd0);
    chk("rst_inst", 64'(ifc.inst), 64'd0);
    chk("rst_inst_pc", ifc.inst_pc, 64'd0);
    chk("rst_inst_err", 64'(ifc.inst_err), 64'd0);
    chk("rst_perf_fetch", ifc.perf_fetch_cnt, 64'd0);
    chk("rst_perf_stall", ifc.perf_stall_cnt, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("first_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("first_req_addr", ifc.imem_addr, RESET_PC);
    tick();
    @(negedge clk);
    chk("edge2_inst_valid", 64'(ifc.inst_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("edge3_inst_valid", 64'(ifc.inst_valid), 64'd1);
    chk("edge3_inst_pc", ifc.inst_pc, RESET_PC);
    repeat (6) tick();

    // Decode stalled from reset: queue fills with two entries, fetch stops.
    ifc.inst_ready = 1'b0;
    apply_reset();
    repeat (12) tick();
    @(negedge clk);
    chk("full_inst_valid", 64'(ifc.inst_valid), 64'd1);
    chk("full_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("full_head_pc", ifc.inst_pc, RESET_PC);
    rdy_pct = 0;
    tick();
    tick();
    d0 = n_deliv;
    ifc.inst_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("full_drained", 64'(n_deliv - d0), 64'd2);
    chk("resume_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("resume_addr", ifc.imem_addr, 64'h8000_0008);
    e0 = n_errs;
    rdy_pct = 100;
    repeat (10) tick();
    @(negedge clk);
    chk("fault_delivered", 64'(n_errs > e0), 64'd1);

    // Redirect while waiting; the response lands one cycle later.
    lat_lo = 1;
    lat_hi = 1;
    repeat (4) tick();
    wait_hs("hs_before_redirect_wait");
    tick();
    do_redirect(64'h8000_0100);
    tick();
    ifc.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdw_flushed", 64'(ifc.inst_valid), 64'd0);
    chk("rdw_no_req", 64'(ifc.imem_req_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("rdw_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("rdw_req_addr", ifc.imem_addr, 64'h8000_0100);
    chk("rdw_dropped", 64'(ifc.inst_valid), 64'd0);
    repeat (8) tick();

    // Redirect in the same cycle as the response, to an unaligned target.
    lat_lo = 0;
    lat_hi = 0;
    repeat (3) tick();
    wait_hs("hs_before_redirect_resp");
    tick();
    do_redirect(64'h8000_0102);
    tick();
    ifc.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdr_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("rdr_req_addr", ifc.imem_addr, 64'h8000_0100);
    chk("rdr_discarded", 64'(ifc.inst_valid), 64'd0);
    repeat (8) tick();

    // Reset asserted while a read is in flight; its late response is stray.
    lat_lo = 2;
    lat_hi = 2;
    repeat (3) tick();
    wait_hs("hs_before_reset");
    tick();
    rst = 1'b0;
    exp_q.delete();
    mdl_pc = RESET_PC;
    #1;
    chk("mid_rst_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("mid_rst_addr", ifc.imem_addr, RESET_PC);
    chk("mid_rst_inst_valid", 64'(ifc.inst_valid), 64'd0);
    chk("mid_rst_inst", 64'(ifc.inst), 64'd0);
    chk("mid_rst_inst_pc", ifc.inst_pc, 64'd0);
    chk("mid_rst_inst_err", 64'(ifc.inst_err), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("stray_no_push", 64'(ifc.inst_valid), 64'd0);
    repeat (10) tick();

    // Randomized traffic: memory latency, both ready signals, redirects.
    lat_lo  = 0;
    lat_hi  = 3;
    rdy_pct = 75;
    d0 = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      tick();
      ifc.redirect_valid = 1'b0;
      ifc.inst_ready = (int'($urandom_range(99, 0)) < 70);
      if ($urandom_range(99, 0) < 3) begin
        t = RESET_PC + 64'($urandom_range(32'h0000_FFFF, 0));
        do_redirect(t);
      end
    end
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.inst_ready     = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    chk("random_progress", 64'(n_deliv - d0 >= 300), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
